conv_cfg_axil_slave: RTL
========================

CONV_CFG_AXIL_SLAVE -- requirements
Module: conv_cfg_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word registers).
REQ-003 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 S_AXI_AWADDR/AWPROT/AWVALID  in  5/3/1  write address channel; AWPROT ignored.
REQ-006 S_AXI_AWREADY  out  1  write address accepted.
REQ-007 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel with byte enables.
REQ-008 S_AXI_WREADY  out  1  write data accepted.
REQ-009 S_AXI_BRESP/BVALID  out  2/1; S_AXI_BREADY  in  1  write response channel.
REQ-010 S_AXI_ARADDR/ARPROT/ARVALID  in  5/3/1; S_AXI_ARREADY  out  1  read address channel.
REQ-011 S_AXI_RDATA/RRESP/RVALID  out  32/2/1; S_AXI_RREADY  in  1  read data channel.
REQ-012 cfg_regs  out  128  registers 0..3 concatenated, reg0 in bits [31:0].
REQ-013 status_in  in  32  layer status, readable at register 4.
REQ-014 start_pulse  out  1  one-cycle convolution start strobe.

Function
REQ-015 Map: word 0-3 RW config, word 4 RO status_in, words 5-7 RO read as 0x00000000; word index = ADDR[4:2], ADDR[1:0] ignored.
REQ-016 Write FSM states: W_IDLE, W_RESP. In W_IDLE, AWREADY=1 until an AW handshake latches the address, and WREADY=1 until a W handshake latches the data; AW and W SHALL be accepted in either order or in the same cycle.
REQ-017 Commit on the edge after both are latched: update the bytes enabled by WSTRB; BVALID=1 from that edge; enter W_RESP; AWREADY=WREADY=0.
REQ-018 Same-cycle AW+W handshake at edge N SHALL give register update and BVALID=1 at edge N+1.
REQ-019 BRESP=OKAY (00) for words 0-3; SLVERR (10) for words 4-7, with no register changed.
REQ-020 BVALID SHALL hold with stable BRESP until BREADY=1, then return to W_IDLE; at most one outstanding write.
REQ-021 Read FSM: ARREADY=1 when RVALID=0; AR handshake at edge N captures the register value at N and sets RVALID=1 at N+1; RDATA/RRESP are held stable until RREADY=1; RRESP is always OKAY.
REQ-022 Read and write channels SHALL be independent; a read of a register captured on the commit edge of a write to it SHALL return the pre-write value.
REQ-023 start_pulse SHALL be 1 for exactly the cycle after a committed reg0 write with WSTRB[0]=1 and WDATA[0]=1; reg0 bit 0 is stored and reads back as written.
REQ-024 WSTRB=0000 to word 0-3 SHALL return OKAY with no change and no start_pulse.

Reset
REQ-025 When ARESETN=0 asynchronously: registers 0-3=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, start_pulse=0, both FSMs idle and latches cleared.
REQ-026 READY outputs SHALL assert no earlier than the first rising edge after ARESETN deasserts; reset mid-transaction SHALL abandon it with no partial register update.

Structure
REQ-027 Shared package conv_cfg_pkg SHALL hold register word indices, RESP_OKAY/RESP_SLVERR, and the write/read state encodings.
REQ-028 A single sub-module conv_cfg_regfile (byte-enabled 4x32 storage plus read mux) SHALL be used; the AXI FSMs stay in the top.

Verification
REQ-029 Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00, 0x04, 0x08, 0x0C, then read each back: BRESP=00, RDATA equals the written value, and cfg_regs matches.
REQ-030 W valid 3 cycles before AW to 0x04 with data 0x12345678 and WSTRB=0101: reg1 becomes 0x00340078 from 0; one BVALID pulse.
REQ-031 Write to 0x10 with status_in=0xCAFE0001: BRESP=10; reading 0x10 returns 0xCAFE0001; reading 0x1C returns 0.
REQ-032 Write 0x00000001 to 0x00 with BREADY held low 5 cycles: start_pulse is high for exactly 1 cycle; BVALID is held 5 cycles; no second AW is accepted meanwhile.
REQ-033 Simultaneous AR and AW+W to 0x08 (old value 0x11, new value 0x22): RDATA=0x11; a subsequent read returns 0x22.
REQ-034 ARESETN pulsed low while BVALID=1: all outputs return to their REQ-025 values immediately; registers read 0 after reset.

Source files
------------

// File: rtl/conv_cfg_pkg.sv
// Shared definitions for the convolution-engine AXI-Lite configuration slave:
// register word map, response codes, FSM encodings and the latched write request.
package conv_cfg_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned WORD_W  = 3;
  localparam int unsigned NUM_CFG = 4;

  localparam logic [WORD_W-1:0] WORD_REG0   = 3'd0;
  localparam logic [WORD_W-1:0] WORD_STATUS = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Words 0..3 are the writable configuration registers.
  function automatic logic is_cfg_word(input logic [WORD_W-1:0] word);
    return word[2] == 1'b0;
  endfunction

endpackage

// File: rtl/conv_cfg_regfile.sv
// Byte-enabled 4x32 configuration storage with the register-map read mux
// (config words, live status word, zero for the unused words).
module conv_cfg_regfile
  import conv_cfg_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [1:0]                wr_word,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [STRB_W-1:0]         wr_strb,
  input  logic [WORD_W-1:0]         rd_word,
  input  logic [DATA_W-1:0]         status_in,
  output logic [DATA_W-1:0]         rd_data_c,
  output logic [NUM_CFG*DATA_W-1:0] cfg_regs
);

  logic [DATA_W-1:0] regs_q [NUM_CFG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CFG; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs_q[wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (is_cfg_word(rd_word)) rd_data_c = regs_q[rd_word[1:0]];
    else if (rd_word == WORD_STATUS) rd_data_c = status_in;
  end

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < NUM_CFG; i++) cfg_regs[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: rtl/conv_cfg_axil_slave.sv
// AXI4-Lite slave exposing the convolution configuration registers, the layer
// status word and a one-cycle start strobe raised by writing reg0 bit 0.
module conv_cfg_axil_slave
  import conv_cfg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CFG*DATA_W-1:0]       cfg_regs,
  input  logic [DATA_W-1:0]               status_in,
  output logic                            start_pulse
);

  logic [0:0] w_state_q, w_state_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  wr_req_t    wr_q, wr_d;
  logic       awready_d, wready_d, bvalid_d, start_d;
  logic [1:0] bresp_d;
  logic       commit_c, reg_we_c;

  logic [0:0]                    r_state_q, r_state_d;
  logic                          arready_d, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_d;
  logic [DATA_W-1:0]             rd_data_c;

  logic unused_c;
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel: latch AW and W independently, commit once both are held.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_d      = wr_q;
    bvalid_d  = S_AXI_BVALID;
    bresp_d   = S_AXI_BRESP;
    start_d   = 1'b0;
    commit_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_done_q && w_done_q) begin
          commit_c  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = is_cfg_word(wr_q.word) ? RESP_OKAY : RESP_SLVERR;
          start_d   = (wr_q.word == WORD_REG0) && wr_q.strb[0] && wr_q.data[0];
          w_state_d = W_RESP;
        end else begin
          if (S_AXI_AWREADY && S_AXI_AWVALID) begin
            aw_done_d = 1'b1;
            wr_d.word = S_AXI_AWADDR[4:2];
          end
          if (S_AXI_WREADY && S_AXI_WVALID) begin
            w_done_d  = 1'b1;
            wr_d.data = DATA_W'(S_AXI_WDATA);
            wr_d.strb = STRB_W'(S_AXI_WSTRB);
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !w_done_d;
  end

  assign reg_we_c = commit_c && is_cfg_word(wr_q.word);

  // Read channel: capture the mux output on the AR handshake, hold until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = S_AXI_RVALID;
    rdata_d   = S_AXI_RDATA;
    case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARREADY && S_AXI_ARVALID) begin
          rvalid_d  = 1'b1;
          rdata_d   = C_S_AXI_DATA_WIDTH'(rd_data_c);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q     <= W_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      wr_q          <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      start_pulse   <= 1'b0;
      r_state_q     <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      w_state_q     <= w_state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      wr_q          <= wr_d;
      S_AXI_AWREADY <= awready_d;
      S_AXI_WREADY  <= wready_d;
      S_AXI_BVALID  <= bvalid_d;
      S_AXI_BRESP   <= bresp_d;
      start_pulse   <= start_d;
      r_state_q     <= r_state_d;
      S_AXI_ARREADY <= arready_d;
      S_AXI_RVALID  <= rvalid_d;
      S_AXI_RDATA   <= rdata_d;
      S_AXI_RRESP   <= RESP_OKAY;
    end
  end

  conv_cfg_regfile u_regfile (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .we        (reg_we_c),
    .wr_word   (wr_q.word[1:0]),
    .wr_data   (wr_q.data),
    .wr_strb   (wr_q.strb),
    .rd_word   (S_AXI_ARADDR[4:2]),
    .status_in (status_in),
    .rd_data_c (rd_data_c),
    .cfg_regs  (cfg_regs)
  );

endmodule
